// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 16;
    localparam int unsigned FETCH_ILEN = 16;

    // Bubble instruction placed in IF/ID (16-bit c.nop encoding).
    localparam logic [15:0] NOP_INSTR = 16'h0001;

    typedef struct packed {
        logic [FETCH_ILEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; clear wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T                         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output T                         o_pop_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !i_clear;
    assign w_do_pop  = i_pop && !i_clear && !o_empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_do_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_do_pop);
            r_count  <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_do_push && o_full && !w_do_pop));
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: credit-limited in-order requests to instruction memory,
// a prefetch FIFO of returned instructions, and the IF/ID pipeline register.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 16,
    parameter int unsigned     ILEN     = 16,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] PCF,
    output logic [ILEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus2D,
    output logic            ValidD
);

    localparam int unsigned     CW     = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] L_STEP = XLEN'(PC_STEP);
    localparam logic [ILEN-1:0] L_NOP  = ILEN'(NOP_INSTR);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [ILEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus_d;
    logic            r_valid_d;

    logic [CW-1:0]   w_fifo_count;
    logic [CW:0]     w_occupancy;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_credit;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    entry_t          w_push_entry;
    entry_t          w_pop_entry;

    // Requests in flight plus buffered entries never exceed DEPTH, so the FIFO cannot overflow.
    assign w_occupancy    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_credit       = (w_occupancy < (CW+1)'(DEPTH));
    assign imem_req_valid = rst && !PCSrcE && w_credit;
    assign imem_req_addr  = r_pcf;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_push       = !PCSrcE && imem_rsp_valid && (r_drop == '0);
    assign w_pop        = !PCSrcE && !FlushD && !StallD && !w_fifo_empty;
    assign w_push_entry = '{instr: imem_rsp_data, pc: r_rsp_pc};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_clear     (PCSrcE),
        .o_pop_data  (w_pop_entry),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcf    <= RESET_PC;
            r_rsp_pc <= RESET_PC;
        end else if (PCSrcE) begin
            r_pcf    <= PCTargetE;
            r_rsp_pc <= PCTargetE;
        end else begin
            if (w_fire) begin
                r_pcf <= r_pcf + L_STEP;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + L_STEP;
            end
        end
    end

    // On redirect every response still owed (minus one landing this cycle) is stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (PCSrcE) begin
            r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
            r_drop        <= r_outstanding - CW'(imem_rsp_valid);
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_d   <= L_NOP;
            r_pc_d      <= '0;
            r_pc_plus_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (FlushD || PCSrcE) begin
            r_instr_d <= L_NOP;
            r_valid_d <= 1'b0;
        end else if (StallD) begin
            r_instr_d   <= r_instr_d;
            r_pc_d      <= r_pc_d;
            r_pc_plus_d <= r_pc_plus_d;
            r_valid_d   <= r_valid_d;
        end else if (!w_fifo_empty) begin
            r_instr_d   <= w_pop_entry.instr;
            r_pc_d      <= w_pop_entry.pc;
            r_pc_plus_d <= w_pop_entry.pc + L_STEP;
            r_valid_d   <= 1'b1;
        end else begin
            r_instr_d <= L_NOP;
            r_valid_d <= 1'b0;
        end
    end

    assign PCF      = r_pcf;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus2D = r_pc_plus_d;
    assign ValidD   = r_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(imem_rsp_valid && (r_outstanding == '0)));
            assert (!(w_push && w_fifo_full && !w_pop));
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: memory model plus an in-order scoreboard of fetched PCs.
`timescale 1ns/1ps
module tb_fetch_prefetch;

    localparam logic [15:0] NOP = 16'h0001;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [15:0] PCTargetE;
    logic        StallD;
    logic        FlushD;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic [15:0] PCF;
    logic [15:0] InstrD;
    logic [15:0] PCD;
    logic [15:0] PCPlus2D;
    logic        ValidD;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;
    int cyc      = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    int rdy_pct  = 100;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    pend_t mem_q[$];
    exp_t  exp_q[$];

    fetch_prefetch #(
        .XLEN(16), .ILEN(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCF            (PCF),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus2D       (PCPlus2D),
        .ValidD         (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model and scoreboard: responses driven just after the rising edge,
    // DUT outputs checked and new requests captured on the falling edge.
    initial begin : mem_mon
        logic        prev_hold;
        logic        prev_bubble;
        logic        last_valid;
        logic [15:0] last_instr;
        logic [15:0] last_pc;
        logic [15:0] last_p2;
        logic [15:0] exp_p2;
        int          last_due;
        int          due;
        exp_t        e;
        pend_t       p;
        prev_hold = 1'b0;
        prev_bubble = 1'b0;
        last_valid = 1'b0;
        last_instr = '0;
        last_pc = '0;
        last_p2 = '0;
        last_due = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                p = mem_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = p.addr;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (!rst) begin
                mem_q.delete();
                exp_q.delete();
                imem_rsp_valid = 1'b0;
                prev_hold = 1'b0;
                prev_bubble = 1'b0;
                last_due = cyc;
            end else begin
                if (prev_hold) begin
                    n_checks++;
                    if (ValidD !== last_valid || PCD !== last_pc || InstrD !== last_instr || PCPlus2D !== last_p2) begin
                        n_fail++;
                        $display("FAIL sb_hold: got v=%b pc=%h instr=%h p2=%h, held v=%b pc=%h instr=%h p2=%h",
                                 ValidD, PCD, InstrD, PCPlus2D, last_valid, last_pc, last_instr, last_p2);
                    end
                end else if (prev_bubble) begin
                    n_checks++;
                    if (ValidD !== 1'b0 || InstrD !== NOP) begin
                        n_fail++;
                        $display("FAIL sb_bubble: got v=%b instr=%h, expected v=0 instr=%h", ValidD, InstrD, NOP);
                    end
                end else if (ValidD === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", PCD, InstrD);
                    end else begin
                        e = exp_q.pop_front();
                        exp_p2 = e.pc + 16'd2;
                        n_popped++;
                        if (PCD !== e.pc || InstrD !== e.instr || PCPlus2D !== exp_p2) begin
                            n_fail++;
                            $display("FAIL sb_order: got pc=%h instr=%h p2=%h, expected pc=%h instr=%h p2=%h",
                                     PCD, InstrD, PCPlus2D, e.pc, e.instr, exp_p2);
                        end
                    end
                end
                last_valid = ValidD;
                last_pc = PCD;
                last_instr = InstrD;
                last_p2 = PCPlus2D;
                prev_hold = StallD && !FlushD && !PCSrcE;
                prev_bubble = FlushD || PCSrcE;
                if (PCSrcE) exp_q.delete();
                if (imem_req_valid && imem_req_ready) begin
                    due = cyc + int'($urandom_range(lat_max, lat_min));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    p.addr = imem_req_addr;
                    p.due  = due;
                    mem_q.push_back(p);
                    e.instr = imem_req_addr;
                    e.pc    = imem_req_addr;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ValidD === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 16'h0 || PCPlus2D !== 16'h0 || PCF !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got req_v=%b v=%b instr=%h pcd=%h p2=%h pcf=%h, expected 0 0 %h 0 0 0",
                     imem_req_valid, ValidD, InstrD, PCD, PCPlus2D, PCF, NOP);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (ValidD !== 1'b0 || PCF !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_cycle1: got v=%b pcf=%h, expected v=0 pcf=0002", ValidD, PCF);
        end
        tick();
        n_checks++;
        if (ValidD !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle2: got v=%b, expected 0", ValidD);
        end
        tick();
        n_checks++;
        if (ValidD !== 1'b1 || PCD !== 16'h0000 || InstrD !== 16'h0000 || PCPlus2D !== 16'h0002) begin
            n_fail++;
            $display("FAIL reset_first_instr: got v=%b pc=%h instr=%h p2=%h, expected 1 0000 0000 0002",
                     ValidD, PCD, InstrD, PCPlus2D);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_pc = 16'(2 * k);
            n_checks++;
            if (ValidD !== 1'b1 || PCD !== exp_pc || PCPlus2D !== exp_pc + 16'd2) begin
                n_fail++;
                $display("FAIL stream_pc: got v=%b pc=%h p2=%h, expected 1 %h %h", ValidD, PCD, PCPlus2D, exp_pc, exp_pc + 16'd2);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] p;
        p = PCD;
        StallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (ValidD !== 1'b1 || PCD !== p) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b pc=%h, expected 1 %h", ValidD, PCD, p);
            end
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_credit: got req_valid=%b, expected 0", imem_req_valid);
        end
        StallD = 1'b0;
        tick();
        n_checks++;
        if (ValidD !== 1'b1 || PCD !== p + 16'd2) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b pc=%h, expected 1 %h", ValidD, PCD, p + 16'd2);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        lat_min = 2;
        lat_max = 2;
        repeat (8) tick();
        PCSrcE = 1'b1;
        PCTargetE = 16'h0040;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_noreq: got req_valid=%b, expected 0", imem_req_valid);
        end
        tick();
        PCSrcE = 1'b0;
        #1;
        n_checks++;
        if (PCF !== 16'h0040 || imem_req_addr !== 16'h0040 || ValidD !== 1'b0 || InstrD !== NOP) begin
            n_fail++;
            $display("FAIL redirect_pc: got pcf=%h addr=%h v=%b instr=%h, expected 0040 0040 0 %h",
                     PCF, imem_req_addr, ValidD, InstrD, NOP);
        end
        wait_valid(20, ok);
        n_checks++;
        if (!ok || PCD !== 16'h0040 || InstrD !== 16'h0040) begin
            n_fail++;
            $display("FAIL redirect_target: got seen=%b pc=%h instr=%h, expected 1 0040 0040", ok, PCD, InstrD);
        end
    endtask

    task automatic test_flush();
        logic [15:0] p;
        lat_min = 1;
        lat_max = 1;
        repeat (5) tick();
        p = PCD;
        n_checks++;
        if (ValidD !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got v=%b, expected 1", ValidD);
        end
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        n_checks++;
        if (ValidD !== 1'b0 || InstrD !== NOP) begin
            n_fail++;
            $display("FAIL flush_bubble: got v=%b instr=%h, expected 0 %h", ValidD, InstrD, NOP);
        end
        tick();
        n_checks++;
        if (ValidD !== 1'b1 || PCD !== p + 16'd2) begin
            n_fail++;
            $display("FAIL flush_next: got v=%b pc=%h, expected 1 %h", ValidD, PCD, p + 16'd2);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        PCSrcE = 1'b1;
        PCTargetE = 16'hFFFC;
        tick();
        PCSrcE = 1'b0;
        wait_valid(20, ok);
        n_checks++;
        if (!ok || PCD !== 16'hFFFC || PCPlus2D !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_first: got seen=%b pc=%h p2=%h, expected 1 fffc fffe", ok, PCD, PCPlus2D);
        end
        tick();
        n_checks++;
        if (ValidD !== 1'b1 || PCD !== 16'hFFFE || PCPlus2D !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_second: got v=%b pc=%h p2=%h, expected 1 fffe 0000", ValidD, PCD, PCPlus2D);
        end
        tick();
        n_checks++;
        if (ValidD !== 1'b1 || PCD !== 16'h0000 || InstrD !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_third: got v=%b pc=%h instr=%h, expected 1 0000 0000", ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_random();
        bit ok;
        int start;
        start = n_popped;
        rdy_pct = 50;
        lat_min = 1;
        lat_max = 3;
        for (int k = 0; k < 300; k++) begin
            tick();
            StallD = ($urandom_range(9) < 2);
            FlushD = ($urandom_range(19) == 0);
            PCSrcE = ($urandom_range(49) == 0);
            PCTargetE = 16'($urandom) & 16'hFFFE;
        end
        tick();
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcE = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (n_popped - start < 30) begin
            n_fail++;
            $display("FAIL random_progress: got %0d instructions, expected at least 30", n_popped - start);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ValidD !== 1'b0 || imem_req_valid !== 1'b0 || InstrD !== NOP || PCF !== 16'h0000) begin
            n_fail++;
            $display("FAIL random_reset: got v=%b req_v=%b instr=%h pcf=%h, expected 0 0 %h 0000",
                     ValidD, imem_req_valid, InstrD, PCF, NOP);
        end
        rdy_pct = 100;
        lat_max = 1;
        tick();
        tick();
        rst = 1'b1;
        wait_valid(20, ok);
        n_checks++;
        if (!ok || PCD !== 16'h0000 || InstrD !== 16'h0000) begin
            n_fail++;
            $display("FAIL random_restart: got seen=%b pc=%h instr=%h, expected 1 0000 0000", ok, PCD, InstrD);
        end
        repeat (6) tick();
    endtask

    initial begin : main
        rst = 1'b0;
        PCSrcE = 1'b0;
        PCTargetE = '0;
        StallD = 1'b0;
        FlushD = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_flush();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
